regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Merges two pipe writebacks and a queued load-unit writeback onto two regfile write ports.
// Optional drop counter output is enabled by defining WB_ARB_DROPCNT_EN.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        A_wr_valid_i,
  input  logic [4:0]  A_wr_addr_i,
  input  logic [31:0] A_wr_data_i,
  input  logic        B_wr_valid_i,
  input  logic [4:0]  B_wr_addr_i,
  input  logic [31:0] B_wr_data_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        A_rd_write_o,
  output logic [4:0]  A_rd_addr_o,
  output logic [31:0] A_rd_data_o,
  output logic        B_rd_write_o,
  output logic [4:0]  B_rd_addr_o,
  output logic [31:0] B_rd_data_o,
  output logic        stall_o
`ifdef WB_ARB_DROPCNT_EN
  ,
  output logic [15:0] drop_count_o
`endif
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, DRAIN, STARVED} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  fifo_addr [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic [2:0]  age;
  logic [2:0]  age_next;

  logic        a_live;
  logic        b_live;
  logic        a_ok;
  logic        b_ok;
  logic        nonempty;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        head_hit;
  logic        drain_a;
  logic        drain_b;
  logic        pop;
  logic        push;

  // Pipe B wins a same-register collision; a queued load older than any pipe write to its register is discarded.
  always_comb begin
    a_live    = A_wr_valid_i && (A_wr_addr_i != 5'd0);
    b_live    = B_wr_valid_i && (B_wr_addr_i != 5'd0);
    a_ok      = a_live && !(b_live && (B_wr_addr_i == A_wr_addr_i));
    b_ok      = b_live;
    nonempty  = (count != 2'd0);
    head_addr = fifo_addr[rd_ptr];
    head_data = fifo_data[rd_ptr];
    head_hit  = nonempty && ((a_live && (A_wr_addr_i == head_addr)) ||
                             (b_live && (B_wr_addr_i == head_addr)));
    drain_a   = nonempty && !head_hit && !a_ok;
    drain_b   = nonempty && !head_hit && a_ok && !b_ok;
    pop       = head_hit || drain_a || drain_b;
    push      = ld_valid_i && ld_ready_o && (ld_addr_i != 5'd0);
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
    age_next = 3'd0;
    if (!pop && nonempty) begin
      age_next = (age == 3'd7) ? 3'd7 : age + 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (push) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && (count_next == 2'd0)) state_next = IDLE;
        else if (!pop && (age >= LIMIT)) state_next = STARVED;
      end
      STARVED: begin
        if (pop) state_next = (count_next == 2'd0) ? IDLE : DRAIN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      count      <= 2'd0;
      age        <= 3'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      ld_ready_o <= 1'b1;
      stall_o    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr[i] <= 5'd0;
        fifo_data[i] <= 32'd0;
      end
    end else begin
      state      <= state_next;
      count      <= count_next;
      age        <= age_next;
      ld_ready_o <= (count_next != 2'd2);
      stall_o    <= (state_next == STARVED);
      if (push) begin
        fifo_addr[wr_ptr] <= ld_addr_i;
        fifo_data[wr_ptr] <= ld_data_i;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Idle ports present zero address and data so stale values never look like a write.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      A_rd_write_o <= 1'b0;
      A_rd_addr_o  <= 5'd0;
      A_rd_data_o  <= 32'd0;
      B_rd_write_o <= 1'b0;
      B_rd_addr_o  <= 5'd0;
      B_rd_data_o  <= 32'd0;
    end else begin
      A_rd_write_o <= a_ok || drain_a;
      A_rd_addr_o  <= a_ok ? A_wr_addr_i : (drain_a ? head_addr : 5'd0);
      A_rd_data_o  <= a_ok ? A_wr_data_i : (drain_a ? head_data : 32'd0);
      B_rd_write_o <= b_ok || drain_b;
      B_rd_addr_o  <= b_ok ? B_wr_addr_i : (drain_b ? head_addr : 5'd0);
      B_rd_data_o  <= b_ok ? B_wr_data_i : (drain_b ? head_data : 32'd0);
    end
  end

`ifdef WB_ARB_DROPCNT_EN
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  always_comb begin
    drop_inc = {1'b0, (a_live && !a_ok)} + {1'b0, head_hit};
    drop_sum = {1'b0, drop_count_o} + {15'd0, drop_inc};
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) drop_count_o <= 16'd0;
    else         drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        A_wr_valid_i, B_wr_valid_i, ld_valid_i;
  logic [4:0]  A_wr_addr_i, B_wr_addr_i, ld_addr_i;
  logic [31:0] A_wr_data_i, B_wr_data_i, ld_data_i;
  logic        ld_ready_o, A_rd_write_o, B_rd_write_o, stall_o;
  logic [4:0]  A_rd_addr_o, B_rd_addr_o;
  logic [31:0] A_rd_data_o, B_rd_data_o;
`ifdef WB_ARB_DROPCNT_EN
  logic [15:0] drop_count_o;
`endif

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .A_wr_valid_i(A_wr_valid_i), .A_wr_addr_i(A_wr_addr_i), .A_wr_data_i(A_wr_data_i),
    .B_wr_valid_i(B_wr_valid_i), .B_wr_addr_i(B_wr_addr_i), .B_wr_data_i(B_wr_data_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .A_rd_write_o(A_rd_write_o), .A_rd_addr_o(A_rd_addr_o), .A_rd_data_o(A_rd_data_o),
    .B_rd_write_o(B_rd_write_o), .B_rd_addr_o(B_rd_addr_o), .B_rd_data_o(B_rd_data_o),
    .stall_o(stall_o)
`ifdef WB_ARB_DROPCNT_EN
    , .drop_count_o(drop_count_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {logic [4:0] addr; logic [31:0] data;} entry_t;

  entry_t      q[$];
  int          m_age = 0;
  bit          m_stall = 0;
  int          m_drops = 0;
  bit          exp_aw, exp_bw;
  logic [4:0]  exp_aa, exp_ba;
  logic [31:0] exp_ad, exp_bd;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_pipes(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                           input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    A_wr_valid_i = av; A_wr_addr_i = aa; A_wr_data_i = ad;
    B_wr_valid_i = bv; B_wr_addr_i = ba; B_wr_data_i = bd;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] a, input logic [31:0] d);
    ld_valid_i = v; ld_addr_i = a; ld_data_i = d;
  endtask

  task automatic model_reset();
    q.delete();
    m_age = 0;
    m_stall = 0;
    m_drops = 0;
  endtask

  // One clock: predict the registered outputs from the current inputs, clock, then compare.
  task automatic step();
    bit a_live, b_live, a_ok, pop, ready;
    int d;
    entry_t h, e;
    check("ld_ready", {31'd0, ld_ready_o}, (q.size() < 2) ? 1 : 0);
    a_live = A_wr_valid_i && (A_wr_addr_i != 0);
    b_live = B_wr_valid_i && (B_wr_addr_i != 0);
    a_ok   = a_live && !(b_live && (A_wr_addr_i == B_wr_addr_i));
    ready  = (q.size() < 2);
    exp_aw = a_ok;   exp_aa = A_wr_addr_i; exp_ad = A_wr_data_i;
    exp_bw = b_live; exp_ba = B_wr_addr_i; exp_bd = B_wr_data_i;
    d   = (a_live && !a_ok) ? 1 : 0;
    pop = 0;
    if (q.size() > 0) begin
      h = q[0];
      if ((a_live && h.addr == A_wr_addr_i) || (b_live && h.addr == B_wr_addr_i)) begin
        pop = 1; d++;
      end else if (!a_ok) begin
        exp_aw = 1; exp_aa = h.addr; exp_ad = h.data; pop = 1;
      end else if (!b_live) begin
        exp_bw = 1; exp_ba = h.addr; exp_bd = h.data; pop = 1;
      end
    end
    m_stall = !pop && (m_stall || (q.size() > 0 && m_age >= LIMIT));
    m_age   = (pop || q.size() == 0) ? 0 : ((m_age < 7) ? m_age + 1 : 7);
    if (pop) void'(q.pop_front());
    if (ld_valid_i && ready && ld_addr_i != 0) begin
      e = {ld_addr_i, ld_data_i};
      q.push_back(e);
    end
    m_drops = (m_drops + d > 65535) ? 65535 : m_drops + d;
    @(posedge clock_i);
    #1;
    check("a_write", {31'd0, A_rd_write_o}, {31'd0, exp_aw});
    if (exp_aw) begin
      check("a_addr", {27'd0, A_rd_addr_o}, {27'd0, exp_aa});
      check("a_data", A_rd_data_o, exp_ad);
    end
    check("b_write", {31'd0, B_rd_write_o}, {31'd0, exp_bw});
    if (exp_bw) begin
      check("b_addr", {27'd0, B_rd_addr_o}, {27'd0, exp_ba});
      check("b_data", B_rd_data_o, exp_bd);
    end
    check("stall", {31'd0, stall_o}, {31'd0, m_stall});
`ifdef WB_ARB_DROPCNT_EN
    check("drop_count", {16'd0, drop_count_o}, m_drops);
`endif
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_a_write"}, {31'd0, A_rd_write_o}, 0);
    check({tag, "_a_addr"}, {27'd0, A_rd_addr_o}, 0);
    check({tag, "_a_data"}, A_rd_data_o, 0);
    check({tag, "_b_write"}, {31'd0, B_rd_write_o}, 0);
    check({tag, "_b_addr"}, {27'd0, B_rd_addr_o}, 0);
    check({tag, "_b_data"}, B_rd_data_o, 0);
    check({tag, "_stall"}, {31'd0, stall_o}, 0);
    check({tag, "_ld_ready"}, {31'd0, ld_ready_o}, 1);
  endtask

  initial begin
    reset_i = 1'b1;
    set_pipes(0, 0, 0, 0, 0, 0);
    set_ld(0, 0, 0);
    model_reset();
    #1;
    check_zeroed("reset");
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;

    // Independent pipe writes land on their own ports.
    set_pipes(1, 5, 32'h11, 1, 6, 32'h22);
    step();
    check("r027_a_addr", {27'd0, A_rd_addr_o}, 5);
    check("r027_b_data", B_rd_data_o, 32'h22);

    // Same-register collision: B wins.
    set_pipes(1, 7, 32'hAA, 1, 7, 32'hBB);
    step();
    check("r028_a_write", {31'd0, A_rd_write_o}, 0);
    check("r028_b_data", B_rd_data_o, 32'hBB);

    // Load drains to free port A one cycle after entering the queue.
    set_pipes(0, 0, 0, 1, 3, 32'h33);
    set_ld(1, 9, 32'h99);
    step();
    set_ld(0, 0, 0);
    step();
    check("r029_a_addr", {27'd0, A_rd_addr_o}, 9);
    check("r029_a_data", A_rd_data_o, 32'h99);
    set_pipes(0, 0, 0, 0, 0, 0);
    step();

    // Starvation: both ports busy until stall, then the load drains.
    set_pipes(1, 1, 32'h101, 1, 2, 32'h202);
    set_ld(1, 9, 32'h55);
    step();
    set_ld(0, 0, 0);
    repeat (5) step();
    check("r030_stall_high", {31'd0, stall_o}, 1);
    set_pipes(0, 0, 0, 0, 0, 0);
    step();
    check("r030_a_addr", {27'd0, A_rd_addr_o}, 9);
    check("r030_a_data", A_rd_data_o, 32'h55);
    check("r030_stall_low", {31'd0, stall_o}, 0);

    // Back-pressure: third load waits for the first pop.
    set_pipes(1, 1, 32'h1, 1, 2, 32'h2);
    set_ld(1, 10, 32'hA0);
    step();
    set_ld(1, 11, 32'hB0);
    step();
    set_ld(1, 12, 32'hC0);
    check("r031_ready_low", {31'd0, ld_ready_o}, 0);
    step();
    step();
    set_pipes(0, 0, 0, 0, 0, 0);
    step();
    check("r031_first_pop", {27'd0, A_rd_addr_o}, 10);
    check("r031_ready_back", {31'd0, ld_ready_o}, 1);
    step();
    set_ld(0, 0, 0);
    step();
    check("r031_third_out", {27'd0, A_rd_addr_o}, 12);
    check("r031_third_data", A_rd_data_o, 32'hC0);

    // Reset with two loads queued discards them.
    set_pipes(1, 1, 32'h1, 1, 2, 32'h2);
    set_ld(1, 20, 32'hD0);
    step();
    set_ld(1, 21, 32'hE0);
    step();
    set_ld(0, 0, 0);
    step();
    #2;
    reset_i = 1'b1;
    #1;
    check_zeroed("r032");
    model_reset();
    set_pipes(0, 0, 0, 0, 0, 0);
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (3) step();
    set_ld(1, 13, 32'h1313);
    step();
    set_ld(0, 0, 0);
    step();
    check("r032_first_accept", {27'd0, A_rd_addr_o}, 13);

    // Randomized traffic; pipes respect stall.
    for (int i = 0; i < 400; i++) begin
      if (m_stall) begin
        set_pipes(0, 0, 0, 0, 0, 0);
      end else begin
        set_pipes(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
      set_ld(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
